// File: rtl/pwr_ctrl_pkg.sv
// Shared types for the power/gesture controller: gesture FSM states,
// off_cause encodings and button channel indices.
package pwr_ctrl_pkg;

    typedef enum logic [1:0] {
        G_IDLE     = 2'd0,
        G_LEFT     = 2'd1,
        G_RIGHT    = 2'd2,
        G_WAIT_REL = 2'd3
    } gest_state_t;

    localparam logic [1:0] OFF_NONE    = 2'd0;
    localparam logic [1:0] OFF_HOLD    = 2'd1;
    localparam logic [1:0] OFF_GESTURE = 2'd2;
    localparam logic [1:0] OFF_IDLE    = 2'd3;

    localparam int BTN_PWR   = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 2;

endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector for N already-synchronised button levels.
// The history register keeps tracking through reset, so a button held across reset release gives no edge.
module btn_edge_det #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic [N-1:0] btn,
    output logic [N-1:0] rise
);

    logic [N-1:0] btn_q;

    always_ff @(posedge clk) begin
        btn_q <= btn;
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/power_gesture_ctrl.sv
// Power-state controller: power button press/hold, left/right swipe gesture
// and optional auto-standby, with one-cycle on/off event pulses.
module power_gesture_ctrl #(
    parameter int HOLD_OFF_CYC    = 300_000_000,
    parameter int GESTURE_WIN_CYC = 500_000_000,
    parameter int IDLE_OFF_CYC    = 0,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on_off_btn,
    input  logic       left_btn,
    input  logic       right_btn,
    input  logic       gesture_en,
    input  logic       activity,
    output logic       machine_state,
    output logic       gesture_busy,
    output logic       pwr_on_evt,
    output logic       pwr_off_evt,
    output logic [1:0] off_cause
);
    import pwr_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] WIN_LIM   = CNT_W'(GESTURE_WIN_CYC);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_OFF_CYC - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [2:0]       rise;
    gest_state_t      g_state, g_next;
    logic [CNT_W-1:0] hold_cnt, win_cnt, idle_cnt;
    logic             lockout;
    logic             nxt_state;
    logic [1:0]       nxt_cause;
    logic             press_on, hold_run, hold_fire, win_open, g_on, g_off;
    logic             idle_clr, idle_fire;

    btn_edge_det #(.N(3)) u_edge (
        .clk  (clk),
        .btn  ({right_btn, left_btn, on_off_btn}),
        .rise (rise)
    );

    assign press_on     = !machine_state && rise[BTN_PWR];
    assign hold_run     = machine_state && on_off_btn && !lockout;
    assign hold_fire    = hold_run && (hold_cnt == HOLD_LAST);
    assign win_open     = gesture_en && (win_cnt < WIN_LIM);
    assign g_on         = win_open && (g_state == G_LEFT)  && rise[BTN_RIGHT];
    assign g_off        = win_open && (g_state == G_RIGHT) && rise[BTN_LEFT];
    assign idle_clr     = activity || on_off_btn || left_btn || right_btn;
    assign idle_fire    = (IDLE_OFF_CYC != 0) && machine_state && !idle_clr && (idle_cnt == IDLE_LAST);
    assign gesture_busy = (g_state == G_LEFT) || (g_state == G_RIGHT);

    // Priority: hold-off beats any gesture result, which beats idle expiry.
    always_comb begin
        nxt_state = machine_state;
        nxt_cause = off_cause;
        if (hold_fire) begin
            nxt_state = 1'b0;
            nxt_cause = OFF_HOLD;
        end else if (press_on || g_on) begin
            nxt_state = 1'b1;
        end else if (g_off) begin
            if (machine_state) begin
                nxt_state = 1'b0;
                nxt_cause = OFF_GESTURE;
            end
        end else if (idle_fire) begin
            nxt_state = 1'b0;
            nxt_cause = OFF_IDLE;
        end
    end

    always_comb begin
        g_next = g_state;
        if (!gesture_en) begin
            g_next = G_IDLE;
        end else begin
            case (g_state)
                G_IDLE: begin
                    if (rise[BTN_LEFT] && rise[BTN_RIGHT]) g_next = G_WAIT_REL;
                    else if (rise[BTN_LEFT])               g_next = G_LEFT;
                    else if (rise[BTN_RIGHT])              g_next = G_RIGHT;
                end
                G_LEFT:     if (g_on  || win_cnt == WIN_LIM) g_next = G_WAIT_REL;
                G_RIGHT:    if (g_off || win_cnt == WIN_LIM) g_next = G_WAIT_REL;
                G_WAIT_REL: if (!left_btn && !right_btn)     g_next = G_IDLE;
                default:    g_next = G_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            machine_state <= 1'b0;
            pwr_on_evt    <= 1'b0;
            pwr_off_evt   <= 1'b0;
            off_cause     <= OFF_NONE;
            g_state       <= G_IDLE;
            hold_cnt      <= '0;
            win_cnt       <= '0;
            idle_cnt      <= '0;
            lockout       <= 1'b0;
        end else begin
            machine_state <= nxt_state;
            off_cause     <= nxt_cause;
            pwr_on_evt    <= !machine_state && nxt_state;
            pwr_off_evt   <= machine_state && !nxt_state;
            g_state       <= g_next;

            if (g_next != g_state)                 win_cnt <= '0;
            else if (gesture_busy && win_cnt < WIN_LIM) win_cnt <= win_cnt + CNT_W'(1);

            // Lockout survives until release so a single press never toggles twice.
            if (!on_off_btn)                 lockout <= 1'b0;
            else if (press_on || hold_fire)  lockout <= 1'b1;

            hold_cnt <= (hold_run && !hold_fire) ? sat_inc(hold_cnt) : '0;

            if (IDLE_OFF_CYC == 0 || !machine_state || idle_clr || nxt_state != machine_state)
                idle_cnt <= '0;
            else
                idle_cnt <= sat_inc(idle_cnt);
        end
    end

endmodule

// File: doc/power_gesture_ctrl.md
Name: power_gesture_ctrl

Overview:
Parametrised successor to the board power-state controller. It keeps the one-bit machine_state (standby/on) and drives it from three sources:
- a short press or long hold on on_off_btn;
- a left/right swipe gesture on left_btn/right_btn, usable only when gesture_en is high;
- a new auto-standby timeout that fires after a period of no user activity.
It sits between the synchronised, debounced button inputs and the top-level mode logic. It also emits single-cycle event pulses so downstream blocks (display, buzzer) can react.

Parameters:
HOLD_OFF_CYC, 300_000_000, on_off_btn must be held this many consecutive cycles while ON to switch OFF
GESTURE_WIN_CYC, 500_000_000, maximum cycles from the first gesture press to the second
IDLE_OFF_CYC, 0, cycles of no activity while ON before auto-standby; 0 disables the feature
CNT_W, 32, width of every internal counter; must hold the largest of the three parameters

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
on_off_btn  input  1  power button level, already synchronised and debounced
left_btn  input  1  left button level, already synchronised and debounced
right_btn  input  1  right button level, already synchronised and debounced
gesture_en  input  1  enables gesture recognition
activity  input  1  level; any other user input this cycle, resets the idle timer
machine_state  output  1  1 = ON, 0 = standby
gesture_busy  output  1  high while a gesture window is open
pwr_on_evt  output  1  one-cycle pulse on every OFF->ON transition
pwr_off_evt  output  1  one-cycle pulse on every ON->OFF transition
off_cause  output  2  cause of the last ON->OFF: 0 none, 1 hold, 2 gesture, 3 idle

Behaviour:
Reset
- rst high at any clock edge, including mid-gesture or mid-hold: machine_state=0, all outputs 0, all counters 0, gesture FSM to G_IDLE, press lockout cleared.
- Reset has priority over every other event.

Rising edges
- Rising edges of each button are detected against one registered copy. A button held high through reset release produces no edge.

Power button
- OFF + on_off_btn rising edge: machine_state=1 on the next edge, pwr_on_evt pulses the same cycle, then lockout is set.
- ON + on_off_btn high with lockout clear: hold_cnt increments each cycle.
- When hold_cnt reaches HOLD_OFF_CYC-1 and the button is still high: machine_state=0, off_cause=1, lockout set. OFF therefore takes effect exactly HOLD_OFF_CYC cycles after the button goes high.
- Release before the count completes: hold_cnt clears and there is no change.
- Lockout clears only when on_off_btn is low, so one press never toggles twice.

Gesture FSM (states G_IDLE, G_LEFT, G_RIGHT, G_WAIT_REL)
- G_IDLE: left rising edge -> G_LEFT; right rising edge -> G_RIGHT; both in the same cycle -> G_WAIT_REL. win_cnt is cleared on entry.
- G_LEFT: a right rising edge while win_cnt < GESTURE_WIN_CYC -> machine_state=1 (pwr_on_evt only if it was OFF), then G_WAIT_REL.
- G_RIGHT: a left rising edge inside the window -> machine_state=0 (pwr_off_evt and off_cause=2 only if it was ON), then G_WAIT_REL.
- Window expiry (win_cnt == GESTURE_WIN_CYC) -> G_WAIT_REL with no power change.
- G_WAIT_REL: return to G_IDLE once both left_btn and right_btn are low.
- gesture_en low forces G_IDLE in the next cycle; an open window is aborted.
- gesture_busy = (state is G_LEFT or G_RIGHT).

Idle timer
- Runs only when IDLE_OFF_CYC != 0 and machine_state=1.
- Clears on activity, on any button high, and on any transition.
- When it reaches IDLE_OFF_CYC-1: machine_state=0, off_cause=3.

Simultaneous events in one cycle (highest priority first)
- rst
- hold-off completion
- gesture result
- idle expiry
- Only the winner changes state; at most one evt pulse per cycle.

Other rules
- Counters saturate; they never wrap.
- off_cause holds its value until the next OFF transition or reset.

Decomposition:
- Shared package pwr_ctrl_pkg: gesture state enum (G_IDLE, G_LEFT, G_RIGHT, G_WAIT_REL) and off_cause encodings (OFF_NONE, OFF_HOLD, OFF_GESTURE, OFF_IDLE).
- One sub-module, btn_edge_det, parametrised by channel count N: registers N inputs and outputs their rising-edge pulses. Instantiated once with N=3.
- All remaining logic stays in power_gesture_ctrl.

Test Plan:
Bench parameters for all scenarios: HOLD_OFF_CYC=8, GESTURE_WIN_CYC=10, IDLE_OFF_CYC=20.
- Short press: OFF, pulse on_off_btn for 2 cycles -> machine_state=1 one cycle after the rise, pwr_on_evt a single cycle. Hold for 7 cycles -> stays ON. Hold for 8 cycles -> OFF exactly 8 cycles after the rise, off_cause=1, no re-toggle before release.
- Gesture on: gesture_en=1, OFF; left rising edge at t, right rising edge at t+5 -> ON at t+6, pwr_on_evt. Repeat with the right edge at t+11 -> no change, FSM in G_WAIT_REL until both buttons are low.
- Gesture off: ON; right edge then left edge 3 cycles later -> OFF, off_cause=2. Dropping gesture_en mid-window -> gesture_busy=0 the next cycle, no state change.
- Idle timeout: ON with no activity -> OFF after 20 cycles, off_cause=3. An activity pulse at cycle 15 -> OFF occurs 20 cycles after that pulse. With IDLE_OFF_CYC=0 -> never times out.
- Collision: the hold-off completion and a gesture-on complete in the same cycle -> result OFF with off_cause=1, exactly one evt pulse.
- Reset: assert rst mid-hold and mid-gesture -> all outputs 0 on the next edge. on_off_btn held high across reset release -> no power-on.
